// File: rtl/apb_cmd_master_if.sv
// Command/response stream and APB bus signals of the APB command requester.
// The master modport is the requester's view; slave is the sequencer/completer side.
interface apb_cmd_master_if;
  logic        iCmdValid;
  logic        oCmdReady;
  logic        iCmdWrite;
  logic [15:0] iCmdAddr;
  logic [31:0] iCmdWdata;
  logic        oRspValid;
  logic [31:0] oRspRdata;
  logic        oRspTimeout;
  logic        oPsel;
  logic        oPenable;
  logic        oPwrite;
  logic [15:0] oPaddr;
  logic [31:0] oPwdata;
  logic [31:0] iPrdata;
  logic        iPready;

  modport master (
    input  iCmdValid, iCmdWrite, iCmdAddr, iCmdWdata, iPrdata, iPready,
    output oCmdReady, oRspValid, oRspRdata, oRspTimeout,
           oPsel, oPenable, oPwrite, oPaddr, oPwdata
  );

  modport slave (
    output iCmdValid, iCmdWrite, iCmdAddr, iCmdWdata, iPrdata, iPready,
    input  oCmdReady, oRspValid, oRspRdata, oRspTimeout,
           oPsel, oPenable, oPwrite, oPaddr, oPwdata
  );
endinterface

// File: rtl/apb_cmd_master.sv
// APB requester: turns a valid/ready command stream into APB transfers and returns one
// response per command, with back-to-back SETUP chaining and a wait-state timeout.
module apb_cmd_master #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input logic              iClk,
  input logic              iRsn,
  apb_cmd_master_if.master bus
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} stateE;

  stateE           stateQ;
  logic [CntW-1:0] waitCnt;
  logic [CntW-1:0] waitNext;
  logic            cmdWrite;
  logic [15:0]     cmdAddr;
  logic [31:0]     cmdWdata;
  logic            psel;
  logic            penable;
  logic            rspValid;
  logic            rspTimeout;
  logic [31:0]     rspRdata;
  logic            timeoutHit;
  logic            xferEnd;
  logic            cmdReady;
  logic            cmdAccept;

  always_comb begin
    waitNext   = (waitCnt == {CntW{1'b1}}) ? waitCnt : waitCnt + CntW'(1);
    // Abort on the stalled ACCESS cycle that would bring the count up to the limit.
    timeoutHit = (TIMEOUT_CYC != 0) && !bus.iPready && (waitNext == CntW'(TIMEOUT_CYC));
    xferEnd    = (stateQ == StAccess) && (bus.iPready || timeoutHit);
    // Gated by reset so ready drops asynchronously along with the registered outputs.
    cmdReady   = iRsn && ((stateQ == StIdle) || xferEnd);
    cmdAccept  = cmdReady && bus.iCmdValid;
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      stateQ     <= StIdle;
      waitCnt    <= '0;
      cmdWrite   <= 1'b0;
      cmdAddr    <= '0;
      cmdWdata   <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      rspValid   <= 1'b0;
      rspTimeout <= 1'b0;
      rspRdata   <= '0;
    end else begin
      rspValid   <= 1'b0;
      rspTimeout <= 1'b0;
      if (cmdAccept) begin
        cmdWrite <= bus.iCmdWrite;
        cmdAddr  <= {bus.iCmdAddr[15:2], 2'b00};
        cmdWdata <= bus.iCmdWrite ? bus.iCmdWdata : 32'h0;
      end
      case (stateQ)
        StIdle: begin
          if (cmdAccept) begin
            stateQ <= StSetup;
            psel   <= 1'b1;
          end
        end
        StSetup: begin
          stateQ  <= StAccess;
          penable <= 1'b1;
        end
        StAccess: begin
          if (xferEnd) begin
            rspValid   <= 1'b1;
            rspTimeout <= !bus.iPready;
            rspRdata   <= (bus.iPready && !cmdWrite) ? bus.iPrdata : 32'h0;
            waitCnt    <= '0;
            penable    <= 1'b0;
            // A command taken on the completing edge chains straight into SETUP.
            if (cmdAccept) begin
              stateQ <= StSetup;
            end else begin
              stateQ <= StIdle;
              psel   <= 1'b0;
            end
          end else begin
            waitCnt <= waitNext;
          end
        end
        default: begin
          stateQ  <= StIdle;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oCmdReady   = cmdReady;
  assign bus.oRspValid   = rspValid;
  assign bus.oRspTimeout = rspTimeout;
  assign bus.oRspRdata   = rspRdata;
  assign bus.oPsel       = psel;
  assign bus.oPenable    = penable;
  assign bus.oPwrite     = cmdWrite;
  assign bus.oPaddr      = cmdAddr;
  assign bus.oPwdata     = cmdWdata;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed scenarios plus randomized commands
// against a queue-based model of expected APB phases and responses.
module tb_apb_cmd_master;
  localparam int unsigned TMO = 16;

  typedef struct {int unsigned waitCyc; logic [31:0] rdata;} planT;
  typedef struct {logic timeout; logic [31:0] rdata;} rspT;
  typedef struct {logic write; logic [15:0] addr; logic [31:0] wdata;} apbT;

  logic iClk;
  logic iRsn;
  int   total;
  int   bad;

  apb_cmd_master_if bus ();

  apb_cmd_master #(.TIMEOUT_CYC(TMO)) dut (
    .iClk(iClk),
    .iRsn(iRsn),
    .bus (bus)
  );

  planT        planQ[$];
  rspT         expRspQ[$];
  rspT         obsRspQ[$];
  apbT         expApbQ[$];
  apbT         obsApbQ[$];
  int unsigned rspEdgeQ[$];
  int unsigned cyc;
  int unsigned pselCyc;
  int unsigned penCyc;
  int unsigned lastAccEdge;

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  always @(posedge iClk) cyc++;

  // Completer: stalls each transfer by its planned number of cycles, then returns its data.
  int unsigned stall;
  int unsigned curWait;
  logic [31:0] curData;
  apbT         setupT;
  always @(negedge iClk) begin
    if (bus.oPsel && !bus.oPenable) begin
      if (planQ.size() > 0) begin
        curWait = planQ[0].waitCyc;
        curData = planQ[0].rdata;
        void'(planQ.pop_front());
      end else begin
        curWait = 0;
        curData = 32'h0;
      end
      stall  = 0;
      setupT = '{bus.oPwrite, bus.oPaddr, bus.oPwdata};
      obsApbQ.push_back(setupT);
    end
    if (bus.oPsel && bus.oPenable) begin
      total++;
      if (bus.oPwrite !== setupT.write || bus.oPaddr !== setupT.addr ||
          bus.oPwdata !== setupT.wdata) begin
        bad++;
        $display("FAIL apb_stable: got w=%0b a=%h d=%h, setup had w=%0b a=%h d=%h",
                 bus.oPwrite, bus.oPaddr, bus.oPwdata, setupT.write, setupT.addr, setupT.wdata);
      end
      if (stall == curWait) begin
        bus.iPready = 1'b1;
        bus.iPrdata = curData;
      end else begin
        bus.iPready = 1'b0;
        bus.iPrdata = $urandom;
        stall++;
      end
    end else begin
      bus.iPready = 1'($urandom_range(0, 1));
      bus.iPrdata = $urandom;
    end
  end

  always @(negedge iClk) begin
    if (bus.oPsel === 1'b1) pselCyc++;
    if (bus.oPenable === 1'b1) penCyc++;
    if (bus.oRspValid === 1'b1) begin
      obsRspQ.push_back('{bus.oRspTimeout, bus.oRspRdata});
      rspEdgeQ.push_back(cyc);
    end else if (iRsn === 1'b1) begin
      total++;
      if (bus.oRspTimeout !== 1'b0) begin
        bad++;
        $display("FAIL timeout_idle: got %0b required 0", bus.oRspTimeout);
      end
    end
  end

  task automatic clear_q();
    planQ.delete();
    expRspQ.delete();
    obsRspQ.delete();
    expApbQ.delete();
    obsApbQ.delete();
    rspEdgeQ.delete();
  endtask

  // Presents one command (valid stays high afterwards) and records what the model expects.
  task automatic send_cmd(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                          input int unsigned waitCyc, input logic [31:0] rdata, output bit ok);
    logic to;
    to = (TMO != 0) && (waitCyc >= TMO);
    planQ.push_back('{waitCyc, rdata});
    expRspQ.push_back('{to, (!wr && !to) ? rdata : 32'h0});
    expApbQ.push_back('{wr, {addr[15:2], 2'b00}, wr ? wdata : 32'h0});
    @(negedge iClk);
    bus.iCmdValid = 1'b1;
    bus.iCmdWrite = wr;
    bus.iCmdAddr  = addr;
    bus.iCmdWdata = wdata;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      #4;
      if (bus.oCmdReady === 1'b1) begin
        ok          = 1'b1;
        lastAccEdge = cyc + 1;
        @(posedge iClk);
        break;
      end
      @(negedge iClk);
    end
  endtask

  task automatic cmd_idle();
    @(negedge iClk);
    bus.iCmdValid = 1'b0;
    bus.iCmdWrite = 1'($urandom_range(0, 1));
    bus.iCmdAddr  = 16'($urandom);
    bus.iCmdWdata = $urandom;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    for (int i = 0; i < budget && obsRspQ.size() < n; i++) @(negedge iClk);
    repeat (3) @(negedge iClk);
  endtask

  task automatic test_reset();
    iRsn = 1'b0;
    bus.iCmdValid = 1'b0;
    bus.iCmdWrite = 1'b0;
    bus.iCmdAddr  = 16'h0;
    bus.iCmdWdata = 32'h0;
    bus.iPready   = 1'b0;
    bus.iPrdata   = 32'h0;
    repeat (2) @(negedge iClk);
    total++;
    if ({bus.oCmdReady, bus.oPsel, bus.oPenable, bus.oPwrite, bus.oRspValid,
         bus.oRspTimeout} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b required 000000", {bus.oCmdReady, bus.oPsel,
               bus.oPenable, bus.oPwrite, bus.oRspValid, bus.oRspTimeout});
    end
    total++;
    if ({bus.oPaddr, bus.oPwdata, bus.oRspRdata} !== 80'h0) begin
      bad++;
      $display("FAIL reset_data: got a=%h wd=%h rd=%h required 0", bus.oPaddr, bus.oPwdata,
               bus.oRspRdata);
    end
    iRsn = 1'b1;
    #1;
    total++;
    if (bus.oCmdReady !== 1'b1) begin
      bad++;
      $display("FAIL idle_ready: got %b required 1", bus.oCmdReady);
    end
  endtask

  task automatic test_write();
    bit ok;
    int unsigned p0, e0;
    clear_q();
    p0 = pselCyc;
    e0 = penCyc;
    send_cmd(1'b1, 16'h4000, 32'hDEADBEEF, 0, 32'h0, ok);
    cmd_idle();
    wait_rsp(1, 50);
    total++;
    if (!ok || obsRspQ.size() != 1 || obsApbQ.size() != 1) begin
      bad++;
      $display("FAIL wr_count: got ok=%0b rsp=%0d required ok=1 rsp=1", ok, obsRspQ.size());
    end else begin
      total++;
      if (obsRspQ[0].timeout !== 1'b0 || obsRspQ[0].rdata !== 32'h0) begin
        bad++;
        $display("FAIL wr_rsp: got to=%0b rd=%h required 0/0", obsRspQ[0].timeout,
                 obsRspQ[0].rdata);
      end
      total++;
      if (obsApbQ[0].addr !== 16'h4000 || obsApbQ[0].wdata !== 32'hDEADBEEF ||
          obsApbQ[0].write !== 1'b1) begin
        bad++;
        $display("FAIL wr_apb: got a=%h d=%h w=%0b required 4000 deadbeef 1", obsApbQ[0].addr,
                 obsApbQ[0].wdata, obsApbQ[0].write);
      end
      // SETUP, ACCESS, then the response cycle: response is seen two edges after acceptance.
      total++;
      if (rspEdgeQ[0] - lastAccEdge != 2) begin
        bad++;
        $display("FAIL wr_latency: got %0d required 2", rspEdgeQ[0] - lastAccEdge);
      end
    end
    total++;
    if (pselCyc - p0 != 2 || penCyc - e0 != 1) begin
      bad++;
      $display("FAIL wr_phases: got psel=%0d pen=%0d required 2/1", pselCyc - p0, penCyc - e0);
    end
  endtask

  task automatic test_wait_read();
    bit ok;
    int unsigned e0;
    clear_q();
    e0 = penCyc;
    send_cmd(1'b0, 16'hA004, 32'h12345678, 2, 32'h00000001, ok);
    cmd_idle();
    wait_rsp(1, 50);
    total++;
    if (!ok || obsRspQ.size() != 1) begin
      bad++;
      $display("FAIL rd_count: got ok=%0b rsp=%0d required 1/1", ok, obsRspQ.size());
    end else begin
      total++;
      if (obsRspQ[0].timeout !== 1'b0 || obsRspQ[0].rdata !== 32'h1) begin
        bad++;
        $display("FAIL rd_rsp: got to=%0b rd=%h required 0/1", obsRspQ[0].timeout,
                 obsRspQ[0].rdata);
      end
      total++;
      if (obsApbQ[0].addr !== 16'hA004 || obsApbQ[0].wdata !== 32'h0 ||
          obsApbQ[0].write !== 1'b0) begin
        bad++;
        $display("FAIL rd_apb: got a=%h d=%h w=%0b required a004 0 0", obsApbQ[0].addr,
                 obsApbQ[0].wdata, obsApbQ[0].write);
      end
    end
    total++;
    if (penCyc - e0 != 3) begin
      bad++;
      $display("FAIL rd_access_len: got %0d required 3", penCyc - e0);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit allOk;
    int unsigned p0, a0;
    logic [31:0] wd[4];
    clear_q();
    p0 = pselCyc;
    allOk = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wd[i] = $urandom;
      send_cmd(1'b1, 16'h4000 + 16'(4 * i), wd[i], 0, 32'h0, ok);
      allOk &= ok;
      if (i == 0) a0 = lastAccEdge;
    end
    cmd_idle();
    wait_rsp(4, 50);
    total++;
    if (!allOk || obsRspQ.size() != 4 || obsApbQ.size() != 4) begin
      bad++;
      $display("FAIL b2b_count: got ok=%0b rsp=%0d required 1/4", allOk, obsRspQ.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (obsApbQ[i].addr !== 16'h4000 + 16'(4 * i) || obsApbQ[i].wdata !== wd[i] ||
            obsRspQ[i].timeout !== 1'b0 || obsRspQ[i].rdata !== 32'h0) begin
          bad++;
          $display("FAIL b2b_xfer%0d: got a=%h d=%h rd=%h required %h %h 0", i,
                   obsApbQ[i].addr, obsApbQ[i].wdata, obsRspQ[i].rdata,
                   16'h4000 + 16'(4 * i), wd[i]);
        end
      end
      total++;
      if (rspEdgeQ[3] - a0 != 8) begin
        bad++;
        $display("FAIL b2b_span: got %0d required 8", rspEdgeQ[3] - a0);
      end
    end
    total++;
    if (pselCyc - p0 != 8) begin
      bad++;
      $display("FAIL b2b_psel: got %0d required 8", pselCyc - p0);
    end
  endtask

  task automatic test_timeout();
    bit ok1, ok2;
    int unsigned e0;
    logic [31:0] wd;
    clear_q();
    e0 = penCyc;
    wd = $urandom;
    send_cmd(1'b0, 16'h6000, 32'h0, 1000, 32'hFFFF0000, ok1);
    // Held valid: the next command must be taken on the aborting edge.
    send_cmd(1'b1, 16'h1234, wd, 1, 32'h0, ok2);
    cmd_idle();
    wait_rsp(2, 100);
    total++;
    if (!ok1 || !ok2 || obsRspQ.size() != 2) begin
      bad++;
      $display("FAIL to_count: got ok=%0b%0b rsp=%0d required 11/2", ok1, ok2, obsRspQ.size());
    end else begin
      total++;
      if (obsRspQ[0].timeout !== 1'b1 || obsRspQ[0].rdata !== 32'h0) begin
        bad++;
        $display("FAIL to_rsp: got to=%0b rd=%h required 1/0", obsRspQ[0].timeout,
                 obsRspQ[0].rdata);
      end
      total++;
      if (lastAccEdge != rspEdgeQ[0]) begin
        bad++;
        $display("FAIL to_next_accept: got edge %0d required %0d", lastAccEdge, rspEdgeQ[0]);
      end
      total++;
      if (obsRspQ[1].timeout !== 1'b0 || obsApbQ[1].addr !== 16'h1234 ||
          obsApbQ[1].wdata !== wd) begin
        bad++;
        $display("FAIL to_next_xfer: got to=%0b a=%h d=%h required 0 1234 %h",
                 obsRspQ[1].timeout, obsApbQ[1].addr, obsApbQ[1].wdata, wd);
      end
    end
    total++;
    if (penCyc - e0 != TMO + 2) begin
      bad++;
      $display("FAIL to_access_len: got %0d required %0d", penCyc - e0, TMO + 2);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    logic [31:0] rd;
    clear_q();
    send_cmd(1'b1, 16'h0004, 32'hCAFEF00D, 5, 32'h0, ok);
    cmd_idle();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge iClk);
      seen = (bus.oPenable === 1'b1);
    end
    total++;
    if (!ok || !seen) begin
      bad++;
      $display("FAIL rst_mid_access: got ok=%0b access=%0b required 1/1", ok, seen);
    end
    #2 iRsn = 1'b0;
    #1;
    total++;
    if ({bus.oPsel, bus.oPenable, bus.oCmdReady, bus.oRspValid} !== 4'b0) begin
      bad++;
      $display("FAIL rst_mid_async: got %b required 0000", {bus.oPsel, bus.oPenable,
               bus.oCmdReady, bus.oRspValid});
    end
    repeat (2) @(negedge iClk);
    iRsn = 1'b1;
    repeat (6) @(negedge iClk);
    total++;
    if (obsRspQ.size() != 0) begin
      bad++;
      $display("FAIL rst_mid_norsp: got %0d responses required 0", obsRspQ.size());
    end
    clear_q();
    rd = $urandom;
    send_cmd(1'b0, 16'h0008, 32'h0, 1, rd, ok);
    cmd_idle();
    wait_rsp(1, 50);
    total++;
    if (!ok || obsRspQ.size() != 1 || obsRspQ[0].rdata !== rd || obsRspQ[0].timeout !== 1'b0)
    begin
      bad++;
      $display("FAIL rst_mid_fresh: got ok=%0b n=%0d required 1/1 rd=%h", ok, obsRspQ.size(),
               rd);
    end
  endtask

  task automatic test_addr_align();
    bit ok;
    clear_q();
    send_cmd(1'b1, 16'h4007, 32'h0BADF00D, 0, 32'h0, ok);
    cmd_idle();
    wait_rsp(1, 50);
    total++;
    if (!ok || obsApbQ.size() != 1 || obsApbQ[0].addr !== 16'h4004) begin
      bad++;
      $display("FAIL addr_align: got ok=%0b a=%h required 4004", ok,
               (obsApbQ.size() > 0) ? obsApbQ[0].addr : 16'hxxxx);
    end
  endtask

  task automatic test_random();
    bit ok;
    bit allOk;
    int unsigned r, w;
    localparam int N = 40;
    clear_q();
    allOk = 1'b1;
    for (int i = 0; i < N; i++) begin
      r = $urandom_range(0, 9);
      w = (r < 6) ? r % 3 : (r == 6) ? TMO - 1 : (r == 7) ? TMO : $urandom_range(TMO + 1, TMO + 4);
      send_cmd(1'($urandom_range(0, 1)), 16'($urandom), $urandom, w, $urandom, ok);
      allOk &= ok;
      if ($urandom_range(0, 2) == 0) begin
        cmd_idle();
        repeat ($urandom_range(0, 3)) @(negedge iClk);
      end
    end
    cmd_idle();
    wait_rsp(N, 3000);
    total++;
    if (!allOk || obsRspQ.size() != N || obsApbQ.size() != N) begin
      bad++;
      $display("FAIL rnd_count: got ok=%0b rsp=%0d apb=%0d required 1/%0d", allOk,
               obsRspQ.size(), obsApbQ.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        total++;
        if (obsRspQ[i].timeout !== expRspQ[i].timeout || obsRspQ[i].rdata !== expRspQ[i].rdata)
        begin
          bad++;
          $display("FAIL rnd_rsp%0d: got to=%0b rd=%h required to=%0b rd=%h", i,
                   obsRspQ[i].timeout, obsRspQ[i].rdata, expRspQ[i].timeout, expRspQ[i].rdata);
        end
        total++;
        if (obsApbQ[i].write !== expApbQ[i].write || obsApbQ[i].addr !== expApbQ[i].addr ||
            obsApbQ[i].wdata !== expApbQ[i].wdata) begin
          bad++;
          $display("FAIL rnd_apb%0d: got w=%0b a=%h d=%h required w=%0b a=%h d=%h", i,
                   obsApbQ[i].write, obsApbQ[i].addr, obsApbQ[i].wdata, expApbQ[i].write,
                   expApbQ[i].addr, expApbQ[i].wdata);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_write();
    test_wait_read();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_addr_align();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
